// File: rtl/fixed_to_float.sv
// fixed_to_float: iterative unsigned fixed-point to IEEE-754 single-precision converter
module fixed_to_float #(
  parameter int FRACS = 20,
  parameter int INTS = 1,
  parameter int WIDTH = INTS + FRACS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic        done,
  output logic [31:0] result
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, NORM} state_t;
  state_t state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0] cnt;
  logic [31:0] al;
  logic [7:0] expo;
  logic unused;
  always_comb begin
    al = 32'(sreg) << (33 - WIDTH);
    expo = 8'(126 + INTS) - 8'(cnt);
    unused = ^{dataa, al[8:0]};
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      done <= 1'b0;
      result <= '0;
      sreg <= '0;
      cnt <= '0;
    end else if (clk_en) begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          sreg <= dataa[WIDTH-1:0];
          cnt <= '0;
          state <= NORM;
        end
      end else if (sreg == '0) begin
        result <= '0;
        done <= 1'b1;
        state <= IDLE;
      end else if (sreg[WIDTH-1]) begin
        result <= {1'b0, expo, al[31:9]};
        done <= 1'b1;
        state <= IDLE;
      end else begin
        sreg <= sreg << 1;
        cnt <= cnt + 1'b1;
      end
    end
endmodule
